// File: rtl/bop_ring.sv
// -----------------------------------------------------------------------------
// bop_ring -- buffer of predictions, parametrised register-based ring FIFO.
//
// Holds predicted target addresses from the front-end predictor until the
// matching instruction is evaluated in MA, where the head entry is popped.
// Adds an occupancy count, a programmable almost-full threshold, optional
// per-entry even parity on stored predictions, and sticky overflow/underflow
// diagnostics.
//
// Ports:
//   s_clk_i          clock, all state updates on its rising edge
//   s_reset_i        synchronous active-high reset
//   s_flush_i        discard all entries (beats push/pop)
//   s_push_i         write s_data_i at the tail
//   s_pop_i          remove the head entry
//   s_clr_err_i      clear the sticky flags (a same-cycle event wins)
//   s_data_i         prediction to push
//   s_data_o         head entry data (undefined when empty)
//   s_entry_ready_o  head valid (count != 0)
//   s_full_o         count == DEPTH
//   s_afull_o        0 < free entries <= AFULL_FREE
//   s_count_o        occupied entries
//   s_perr_o         head parity mismatch (0 when PARITY == 0)
//   s_ovf_o          sticky: push dropped because full
//   s_udf_o          sticky: pop while empty
// -----------------------------------------------------------------------------
module bop_ring #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AFULL_FREE = 1,
  parameter int unsigned PARITY     = 1,
  localparam int unsigned CW        = $clog2(DEPTH + 1),
  localparam int unsigned PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             s_clk_i,
  input  logic             s_reset_i,
  input  logic             s_flush_i,
  input  logic             s_push_i,
  input  logic             s_pop_i,
  input  logic             s_clr_err_i,
  input  logic [WIDTH-1:0] s_data_i,
  output logic [WIDTH-1:0] s_data_o,
  output logic             s_entry_ready_o,
  output logic             s_full_o,
  output logic             s_afull_o,
  output logic [CW-1:0]    s_count_o,
  output logic             s_perr_o,
  output logic             s_ovf_o,
  output logic             s_udf_o
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [PW-1:0]               wp_q, wp_d;
  logic [PW-1:0]               rp_q, rp_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        ovf_q, ovf_d;
  logic                        udf_q, udf_d;

  logic is_full, is_empty;
  logic push_ok, pop_ok, ovf_evt, udf_evt, we;
  logic [CW-1:0] free_cnt;

  assign is_full  = (cnt_q == CW'(DEPTH));
  assign is_empty = (cnt_q == '0);

  // A push into a full ring is still accepted when the head leaves the same cycle.
  assign push_ok = s_push_i & (~is_full | s_pop_i);
  assign pop_ok  = s_pop_i & ~is_empty;
  assign ovf_evt = s_push_i & is_full & ~s_pop_i;
  assign udf_evt = s_pop_i & is_empty;
  assign we      = push_ok & ~s_flush_i;

  // NOTE: every variable written in always_comb is given a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    ovf_d  = ovf_q & ~s_clr_err_i;
    udf_d  = udf_q & ~s_clr_err_i;

    if (s_flush_i) begin
      // Flush drops everything, ignores same-cycle push/pop, keeps the flags.
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) begin
        data_d[wp_d] = s_data_i;
        wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
      end
      if (pop_ok) begin
        rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
      ovf_d = ovf_d | ovf_evt;
      udf_d = udf_d | udf_evt;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of process order.
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // NOTE: entry storage has no reset; validity is tracked by the counter,
  // so clearing the array would only cost a reset net on every data flop.
  always_ff @(posedge s_clk_i) begin
    data_q <= data_d;
  end

  if (PARITY != 0) begin : g_par
    logic [DEPTH-1:0] par_q, par_d;

    always_comb begin
      par_d = par_q;
      if (we) par_d[wp_q] = ^s_data_i;
    end

    always_ff @(posedge s_clk_i) begin
      par_q <= par_d;
    end

    assign s_perr_o = s_entry_ready_o & (par_q[rp_q] != ^data_q[rp_q]);
  end else begin : g_nopar
    assign s_perr_o = 1'b0;
  end

  assign free_cnt        = CW'(DEPTH) - cnt_q;
  assign s_data_o        = data_q[rp_q];
  assign s_entry_ready_o = ~is_empty;
  assign s_full_o        = is_full;
  assign s_afull_o       = (free_cnt != '0) && (free_cnt <= CW'(AFULL_FREE));
  assign s_count_o       = cnt_q;
  assign s_ovf_o         = ovf_q;
  assign s_udf_o         = udf_q;

endmodule

// File: tb/tb_bop_ring.sv
// -----------------------------------------------------------------------------
// tb_bop_ring -- directed self-checking bench for bop_ring.
// Instance dut:  DEPTH=4, WIDTH=32, AFULL_FREE=1, PARITY=1.
// Instance dut3: DEPTH=3, WIDTH=16, for pointer wrap on a non-power-of-two depth.
// -----------------------------------------------------------------------------
module tb_bop_ring;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        push = 1'b0, pop = 1'b0, flush = 1'b0, clr = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        ready, full, afull, perr, ovf, udf;
  logic [2:0]  cnt;

  logic        push3 = 1'b0, pop3 = 1'b0;
  logic [15:0] din3 = '0;
  logic [15:0] dout3;
  logic        ready3, full3, afull3, perr3, ovf3, udf3;
  logic [1:0]  cnt3;

  int n_cmp = 0;
  int n_err = 0;

  bop_ring #(.WIDTH(32), .DEPTH(4), .AFULL_FREE(1), .PARITY(1)) dut (
    .s_clk_i(clk), .s_reset_i(reset), .s_flush_i(flush), .s_push_i(push),
    .s_pop_i(pop), .s_clr_err_i(clr), .s_data_i(din), .s_data_o(dout),
    .s_entry_ready_o(ready), .s_full_o(full), .s_afull_o(afull),
    .s_count_o(cnt), .s_perr_o(perr), .s_ovf_o(ovf), .s_udf_o(udf)
  );

  bop_ring #(.WIDTH(16), .DEPTH(3), .AFULL_FREE(1), .PARITY(1)) dut3 (
    .s_clk_i(clk), .s_reset_i(reset), .s_flush_i(1'b0), .s_push_i(push3),
    .s_pop_i(pop3), .s_clr_err_i(1'b0), .s_data_i(din3), .s_data_o(dout3),
    .s_entry_ready_o(ready3), .s_full_o(full3), .s_afull_o(afull3),
    .s_count_o(cnt3), .s_perr_o(perr3), .s_ovf_o(ovf3), .s_udf_o(udf3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic po, input logic fl,
                       input logic cl, input logic [31:0] d);
    push = p; pop = po; flush = fl; clr = cl; din = d;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_ready"}, ready, 0);
    check({pfx, "_full"},  full,  0);
    check({pfx, "_afull"}, afull, 0);
    check({pfx, "_count"}, cnt,   0);
    check({pfx, "_perr"},  perr,  0);
    check({pfx, "_ovf"},   ovf,   0);
    check({pfx, "_udf"},   udf,   0);
  endtask

  localparam logic [31:0] A = 32'hA0A0_0001;
  localparam logic [31:0] B = 32'hB1B1_0002;
  localparam logic [31:0] C = 32'hC2C2_0003;
  localparam logic [31:0] D = 32'hD3D3_0004;
  localparam logic [31:0] E = 32'hE4E4_0005;

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check_reset_vals("rst");

    // Fill: count steps, almost-full at 3, full at 4.
    drive(1, 0, 0, 0, A);
    check("fill1_cnt", cnt, 1);
    check("fill1_ready", ready, 1);
    check("fill1_head", dout, A);
    drive(1, 0, 0, 0, B);
    check("fill2_cnt", cnt, 2);
    check("fill2_afull", afull, 0);
    drive(1, 0, 0, 0, C);
    check("fill3_cnt", cnt, 3);
    check("fill3_afull", afull, 1);
    check("fill3_full", full, 0);
    drive(1, 0, 0, 0, D);
    check("fill4_cnt", cnt, 4);
    check("fill4_full", full, 1);
    check("fill4_afull", afull, 0);
    check("fill4_head", dout, A);

    // Push while full without pop: dropped, overflow flagged.
    drive(1, 0, 0, 0, 32'hDEAD_BEEF);
    check("ovf_flag", ovf, 1);
    check("ovf_cnt", cnt, 4);
    check("ovf_head", dout, A);

    // Push with pop while full: both accepted, overflow stays sticky.
    drive(1, 1, 0, 0, E);
    check("fullpp_cnt", cnt, 4);
    check("fullpp_head", dout, B);
    check("fullpp_ovf", ovf, 1);

    drive(0, 1, 0, 0, 0);
    check("pop1_head", dout, C);
    check("pop1_cnt", cnt, 3);
    drive(0, 1, 0, 0, 0);
    check("pop2_head", dout, D);
    drive(0, 1, 0, 0, 0);
    check("pop3_head", dout, E);
    drive(0, 1, 0, 0, 0);
    check("pop4_ready", ready, 0);
    check("pop4_cnt", cnt, 0);
    check("pop4_udf", udf, 0);

    // Pop on empty with clear in the same cycle: set wins for udf, ovf clears.
    drive(0, 1, 0, 1, 0);
    check("udfclr_udf", udf, 1);
    check("udfclr_ovf", ovf, 0);
    check("udfclr_cnt", cnt, 0);
    drive(0, 0, 0, 1, 0);
    check("clr_udf", udf, 0);
    check("clr_ovf", ovf, 0);

    // Parity: store 0x1, then corrupt storage so the head data reads as 0.
    drive(1, 0, 0, 0, 32'h0000_0001);
    check("par_head", dout, 32'h1);
    check("par_ok", perr, 0);
    force dut.data_q = '0;
    #1;
    check("par_err", perr, 1);
    drive(0, 1, 0, 0, 0);
    check("par_pop_perr", perr, 0);
    check("par_pop_cnt", cnt, 0);
    release dut.data_q;

    // Flush with push and pop at count 3: ring empties, sticky udf kept.
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, A);
    drive(1, 0, 0, 0, B);
    drive(1, 0, 0, 0, C);
    check("preflush_cnt", cnt, 3);
    drive(1, 1, 1, 0, D);
    check("flush_cnt", cnt, 0);
    check("flush_ready", ready, 0);
    check("flush_udf", udf, 1);
    check("flush_ovf", ovf, 0);
    drive(1, 0, 0, 0, E);
    check("postflush_head", dout, E);
    check("postflush_cnt", cnt, 1);

    // Reset with count 2 and push active.
    drive(1, 0, 0, 0, B);
    check("prerst_cnt", cnt, 2);
    reset = 1'b1;
    drive(1, 0, 0, 0, C);
    reset = 1'b0;
    check_reset_vals("rst2");
    drive(1, 0, 0, 0, D);
    check("rst2_first_head", dout, D);
    check("rst2_first_ready", ready, 1);
    check("rst2_first_cnt", cnt, 1);
    idle();

    // DEPTH=3: steady push+pop at count 1 across several pointer wraps.
    push3 = 1'b1; din3 = 16'h1000;
    tick();
    check("d3_init_head", dout3, 16'h1000);
    check("d3_init_cnt", cnt3, 1);
    pop3 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      din3 = 16'h1000 + 16'(i);
      tick();
      check($sformatf("d3_pp%0d_head", i), dout3, 16'h1000 + 16'(i));
      check($sformatf("d3_pp%0d_cnt", i), cnt3, 1);
    end
    push3 = 1'b0; pop3 = 1'b0;
    tick();
    check("d3_perr", perr3, 0);
    check("d3_flags", {ovf3, udf3}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
